cluster_load_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the compute-cluster/memory wrapper.
- On a start pulse it walks the filter memory, then one IFM chunk, into the cluster's input buffers by driving the write valid/count/select indices.
- It then launches the compute run and waits for chunk-end.
- Double-buffer select toggles per job, so the next job's load targets the other buffer half.

---
 rtl/cluster_load_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cluster_load_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cluster_load_ctrl.sv
// Job sequencer ahead of the compute cluster: loads filters, then one IFM chunk,
// launches the run and ping-pongs the double-buffer select between jobs.
module cluster_load_ctrl #(
    parameter int WR_CYC_NUM  = 4,
    parameter int FILTER_NUM  = 4,
    parameter int IFM_NUM     = 8,
    parameter int OUT_BUF_NUM = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              start_i,
    input  logic                                              skip_filter_i,
    input  logic [((IFM_NUM > 1) ? $clog2(IFM_NUM) : 1)-1:0]         ifm_chunk_i,
    input  logic                                              total_chunk_end_i,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic                                              filter_wr_valid_o,
    output logic [((WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1)-1:0]   filter_wr_count_o,
    output logic [((OUT_BUF_NUM > 1) ? $clog2(OUT_BUF_NUM) : 1)-1:0] filter_wr_order_sel_o,
    output logic                                              filter_wr_sel_o,
    output logic                                              filter_rd_sel_o,
    output logic                                              ifm_wr_valid_o,
    output logic [((WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1)-1:0]   ifm_wr_count_o,
    output logic [((IFM_NUM > 1) ? $clog2(IFM_NUM) : 1)-1:0]         ifm_wr_chunk_count_o,
    output logic                                              ifm_wr_sel_o,
    output logic                                              ifm_rd_sel_o,
    output logic                                              run_valid_o,
    output logic                                              total_chunk_start_o
);

    localparam int BW = (WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1;
    localparam int FW = (OUT_BUF_NUM > 1) ? $clog2(OUT_BUF_NUM) : 1;
    localparam int CW = (IFM_NUM > 1) ? $clog2(IFM_NUM) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(WR_CYC_NUM - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_FILT = 3'd1,
        ST_LOAD_IFM  = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [BW-1:0] beat_r, beat_s;
    logic [FW-1:0] filt_r, filt_s;
    logic [CW-1:0] chunk_r, chunk_s;
    logic          sel_r, sel_s;

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
            filt_r  <= '0;
            chunk_r <= '0;
            sel_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            filt_r  <= filt_s;
            chunk_r <= chunk_s;
            sel_r   <= sel_s;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        filt_s  = filt_r;
        chunk_s = chunk_r;
        sel_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    chunk_s = ifm_chunk_i;
                    beat_s  = '0;
                    filt_s  = '0;
                    state_s = skip_filter_i ? ST_LOAD_IFM : ST_LOAD_FILT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_FILT: begin
                if (beat_r == BEAT_LAST) begin
                    beat_s = '0;
                    if (filt_r == FILT_LAST) begin
                        filt_s  = '0;
                        state_s = ST_LOAD_IFM;
                    end else begin
                        filt_s = filt_r + {{(FW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    beat_s = beat_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            ST_LOAD_IFM: begin
                if (beat_r == BEAT_LAST) begin
                    beat_s  = '0;
                    state_s = ST_RUN;
                end else begin
                    beat_s = beat_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (total_chunk_end_i) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                sel_s   = ~sel_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = '0;
                filt_s  = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so strobes and indices
    // appear in the same cycle as the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o                <= 1'b0;
            done_o                <= 1'b0;
            filter_wr_valid_o     <= 1'b0;
            filter_wr_count_o     <= '0;
            filter_wr_order_sel_o <= '0;
            filter_wr_sel_o       <= 1'b0;
            filter_rd_sel_o       <= 1'b0;
            ifm_wr_valid_o        <= 1'b0;
            ifm_wr_count_o        <= '0;
            ifm_wr_chunk_count_o  <= '0;
            ifm_wr_sel_o          <= 1'b0;
            ifm_rd_sel_o          <= 1'b0;
            run_valid_o           <= 1'b0;
            total_chunk_start_o   <= 1'b0;
        end else begin
            busy_o                <= (state_s != ST_IDLE);
            done_o                <= (state_s == ST_DONE);
            filter_wr_valid_o     <= (state_s == ST_LOAD_FILT);
            filter_wr_count_o     <= (state_s == ST_LOAD_FILT) ? beat_s : '0;
            filter_wr_order_sel_o <= (state_s == ST_LOAD_FILT) ? filt_s : '0;
            filter_wr_sel_o       <= sel_s;
            filter_rd_sel_o       <= (state_s == ST_RUN) ? sel_s : ~sel_s;
            ifm_wr_valid_o        <= (state_s == ST_LOAD_IFM);
            ifm_wr_count_o        <= (state_s == ST_LOAD_IFM) ? beat_s : '0;
            ifm_wr_chunk_count_o  <= chunk_s;
            ifm_wr_sel_o          <= sel_s;
            ifm_rd_sel_o          <= (state_s == ST_RUN) ? sel_s : ~sel_s;
            run_valid_o           <= (state_s == ST_RUN);
            total_chunk_start_o   <= (state_s == ST_RUN) && (state_r == ST_LOAD_IFM);
        end
    end

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Scoreboard bench for cluster_load_ctrl: expected write beats are queued at
// job start and matched against every strobe the DUT produces.
module tb_cluster_load_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       skip_filter = 1'b0;
    logic [2:0] ifm_chunk = 3'd0;
    logic       total_chunk_end = 1'b0;
    logic       busy, done, filter_wr_valid, filter_wr_sel, filter_rd_sel;
    logic [1:0] filter_wr_count, filter_wr_order_sel, ifm_wr_count;
    logic       ifm_wr_valid, ifm_wr_sel, ifm_rd_sel, run_valid, total_chunk_start;
    logic [2:0] ifm_wr_chunk_count;

    cluster_load_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .skip_filter_i(skip_filter),
        .ifm_chunk_i(ifm_chunk), .total_chunk_end_i(total_chunk_end),
        .busy_o(busy), .done_o(done), .filter_wr_valid_o(filter_wr_valid),
        .filter_wr_count_o(filter_wr_count), .filter_wr_order_sel_o(filter_wr_order_sel),
        .filter_wr_sel_o(filter_wr_sel), .filter_rd_sel_o(filter_rd_sel),
        .ifm_wr_valid_o(ifm_wr_valid), .ifm_wr_count_o(ifm_wr_count),
        .ifm_wr_chunk_count_o(ifm_wr_chunk_count), .ifm_wr_sel_o(ifm_wr_sel),
        .ifm_rd_sel_o(ifm_rd_sel), .run_valid_o(run_valid),
        .total_chunk_start_o(total_chunk_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_ifm;
        int cyc;
        int cnt;
        int ord;
        int chunk;
        bit sel;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    bit    exp_sel = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (done) done_cnt++;
            if (filter_wr_valid && ifm_wr_valid) check_val("both_valid", 1, 0);
            if (filter_wr_valid || ifm_wr_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("beat_kind", {31'd0, ifm_wr_valid}, {31'd0, e.is_ifm});
                    check_val("beat_cyc", cyc, e.cyc);
                    if (e.is_ifm) begin
                        check_val("ifm_count", {30'd0, ifm_wr_count}, e.cnt);
                        check_val("ifm_chunk", {29'd0, ifm_wr_chunk_count}, e.chunk);
                        check_val("ifm_wr_sel", {31'd0, ifm_wr_sel}, {31'd0, e.sel});
                    end else begin
                        check_val("filt_count", {30'd0, filter_wr_count}, e.cnt);
                        check_val("filt_order", {30'd0, filter_wr_order_sel}, e.ord);
                        check_val("filt_wr_sel", {31'd0, filter_wr_sel}, {31'd0, e.sel});
                    end
                end
            end
        end
    end

    function automatic logic [18:0] all_outs();
        return {busy, done, filter_wr_valid, filter_wr_count, filter_wr_order_sel,
                filter_wr_sel, filter_rd_sel, ifm_wr_valid, ifm_wr_count,
                ifm_wr_chunk_count, ifm_wr_sel, ifm_rd_sel, run_valid, total_chunk_start};
    endfunction

    // Queue the beats a job should produce, relative to start cycle c0
    task automatic push_beats(input int c0, input bit skip, input int chunk);
        beat_t e;
        int base;
        base = c0 + 1;
        if (!skip) begin
            for (int f = 0; f < 4; f++) begin
                for (int b = 0; b < 4; b++) begin
                    e = '{1'b0, base + f * 4 + b, b, f, 0, exp_sel};
                    exp_q.push_back(e);
                end
            end
            base = base + 16;
        end
        for (int b = 0; b < 4; b++) begin
            e = '{1'b1, base + b, b, 0, chunk, exp_sel};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_job(input bit skip, input logic [2:0] chunk, input int end_delay, input bit poke);
        int c0;
        int d0;
        c0 = cyc;
        d0 = done_cnt;
        push_beats(c0, skip, chunk);
        start = 1'b1;
        skip_filter = skip;
        ifm_chunk = chunk;
        step();
        start = 1'b0;
        skip_filter = ~skip;
        ifm_chunk = ~chunk;
        check_val("busy_on", {31'd0, busy}, 1);
        if (poke) begin
            step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 0; k < 100; k++) begin
            if (run_valid) break;
            step();
        end
        check_val("run_seen", {31'd0, run_valid}, 1);
        check_val("run_cyc", cyc, c0 + (skip ? 5 : 21));
        check_val("start_pulse", {31'd0, total_chunk_start}, 1);
        check_val("rd_sel_run", {30'd0, filter_rd_sel, ifm_rd_sel}, {30'd0, exp_sel, exp_sel});
        check_val("wr_sel_run", {30'd0, filter_wr_sel, ifm_wr_sel}, {30'd0, exp_sel, exp_sel});
        for (int i = 0; i < end_delay; i++) begin
            step();
            if (i == 0) check_val("start_pulse_once", {31'd0, total_chunk_start}, 0);
            check_val("run_hold", {31'd0, run_valid}, 1);
        end
        total_chunk_end = 1'b1;
        step();
        total_chunk_end = 1'b0;
        check_val("run_drop", {31'd0, run_valid}, 0);
        check_val("done_pulse", {31'd0, done}, 1);
        check_val("busy_done", {31'd0, busy}, 1);
        if (poke) start = 1'b1;
        step();
        start = 1'b0;
        exp_sel = ~exp_sel;
        check_val("done_once", {31'd0, done}, 0);
        check_val("busy_off", {31'd0, busy}, 0);
        check_val("wr_sel_flip", {30'd0, filter_wr_sel, ifm_wr_sel}, {30'd0, exp_sel, exp_sel});
        check_val("rd_sel_idle", {30'd0, filter_rd_sel, ifm_rd_sel}, {30'd0, ~exp_sel, ~exp_sel});
        step();
        check_val("stay_idle", {31'd0, busy}, 0);
        check_val("done_count", done_cnt - d0, 1);
        check_val("beats_left", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        repeat (2) step();
        check_val("reset_outs", {13'd0, all_outs()}, 0);
        rst = 1'b0;
        step();
        check_val("idle_busy", {31'd0, busy}, 0);

        // Full job with ignored starts in LOAD_FILT and DONE
        run_job(1'b0, 3'd5, 10, 1'b1);

        // Abort during beat 2 of filter 1 (sel currently 1)
        c0 = cyc;
        push_beats(c0, 1'b0, 3);
        start = 1'b1;
        ifm_chunk = 3'd3;
        skip_filter = 1'b0;
        step();
        start = 1'b0;
        repeat (6) step();
        check_val("abort_pos", {28'd0, filter_wr_order_sel, filter_wr_count}, {28'd0, 2'd1, 2'd2});
        rst = 1'b1;
        #1;
        check_val("abort_outs", {13'd0, all_outs()}, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        exp_sel = 1'b0;
        step();
        check_val("abort_sel", {30'd0, filter_wr_sel, ifm_wr_sel}, 0);

        // Fresh job after abort restarts from filter 0, beat 0
        run_job(1'b0, 3'd1, 3, 1'b0);

        // Stray end in IDLE, then a skip-filter job ending on its first RUN cycle
        total_chunk_end = 1'b1;
        step();
        total_chunk_end = 1'b0;
        check_val("stray_end", {30'd0, busy, done}, 0);
        step();
        run_job(1'b1, 3'd7, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
